// File: rtl/lif_neuron_pkg.sv
// lif_neuron_pkg: shared time-step width and neuron state encoding.
package lif_neuron_pkg;
    localparam int TIME_STEP_W = 8;
    typedef enum logic {ST_INTEG = 1'b0, ST_REFRACT = 1'b1} state_t;
endpackage

// File: rtl/lif_accum.sv
// lif_accum: combinational leak + weighted accumulate with saturation for one synapse.
module lif_accum #(
    parameter int WEIGHT_SIZE = 16,
    parameter int POT_SIZE    = 20,
    parameter int LEAK_SHIFT  = 4
) (
    input  logic [POT_SIZE-1:0]    membrane,
    input  logic [WEIGHT_SIZE-1:0] weight,
    input  logic                   spk_pre,
    input  logic                   step_tick,
    output logic [POT_SIZE-1:0]    v_next
);
    logic [POT_SIZE-1:0] leak;
    logic [POT_SIZE-1:0] leaked;
    logic [POT_SIZE:0]   sum;
    always_comb begin
        leak   = step_tick ? (membrane >> LEAK_SHIFT) : '0;
        leaked = membrane - leak;
        sum    = {1'b0, leaked} + (spk_pre ? (POT_SIZE+1)'(weight) : '0);
        v_next = sum[POT_SIZE] ? '1 : sum[POT_SIZE-1:0];
    end
endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with refractory hold-off and
// the free-running time-step counter shared with the plasticity logic.
module lif_neuron
    import lif_neuron_pkg::*;
#(
    parameter int          WEIGHT_SIZE   = 16,
    parameter int          POT_SIZE      = 20,
    parameter int unsigned THRESHOLD     = 1000,
    parameter int          LEAK_SHIFT    = 4,
    parameter int unsigned REFRACT_STEPS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_tick,
    input  logic                   spk_pre,
    input  logic [WEIGHT_SIZE-1:0] weight,
    output logic [TIME_STEP_W-1:0] time_step,
    output logic                   spk_post,
    output logic [TIME_STEP_W-1:0] spk_time,
    output logic [POT_SIZE-1:0]    membrane,
    output logic                   refract
);
    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [TIME_STEP_W-1:0] ts_q, ts_d, spk_time_q, spk_time_d;
    logic [POT_SIZE-1:0]    mem_q, mem_d, v_next;
    logic                   spk_q, spk_d, fire, leave;

    lif_accum #(
        .WEIGHT_SIZE(WEIGHT_SIZE),
        .POT_SIZE   (POT_SIZE),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_accum (
        .membrane (mem_q),
        .weight   (weight),
        .spk_pre  (spk_pre),
        .step_tick(step_tick),
        .v_next   (v_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INTEG;
        else     state_q <= state_d;
    end

    always_comb begin
        fire    = (state_q == ST_INTEG) && (v_next >= POT_SIZE'(THRESHOLD));
        leave   = (state_q == ST_REFRACT) && step_tick && (cnt_q == 8'd1);
        state_d = fire ? ST_REFRACT : leave ? ST_INTEG : state_q;
    end

    // The tick that ends refractory applies neither leak nor accumulate, so membrane stays 0.
    always_comb begin
        ts_d       = ts_q + TIME_STEP_W'(step_tick);
        spk_d      = fire;
        spk_time_d = fire ? ts_q : spk_time_q;
        mem_d      = (state_q == ST_INTEG && !fire) ? v_next : '0;
        cnt_d      = fire ? 8'(REFRACT_STEPS)
                   : (state_q == ST_REFRACT && step_tick) ? cnt_q - 8'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            ts_q       <= '0;
            spk_time_q <= '0;
            mem_q      <= '0;
            spk_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ts_q       <= ts_d;
            spk_time_q <= spk_time_d;
            mem_q      <= mem_d;
            spk_q      <= spk_d;
        end
    end

    assign time_step = ts_q;
    assign spk_post  = spk_q;
    assign spk_time  = spk_time_q;
    assign membrane  = mem_q;
    assign refract   = (state_q == ST_REFRACT);
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: scoreboard bench; a behavioural neuron model predicts every cycle of a
// default-threshold neuron and a saturation-threshold neuron driven by the same stimulus.
module tb_lif_neuron;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_tick = 1'b0;
    logic        spk_pre = 1'b0;
    logic [15:0] weight = '0;
    logic [7:0]  ts0, st0, ts1, st1;
    logic [19:0] mem0, mem1;
    logic        spk0, rf0, spk1, rf1;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [19:0] mem;
        logic        spk;
        logic [7:0]  st;
        logic        rf;
        logic [7:0]  ts;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int unsigned mv[2], mts[2], mleft[2], mst[2], mspk[2];
    int unsigned thr[2] = '{1000, 1048575};

    always #5 clk = ~clk;

    lif_neuron dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .spk_pre(spk_pre), .weight(weight),
        .time_step(ts0), .spk_post(spk0), .spk_time(st0), .membrane(mem0), .refract(rf0)
    );

    lif_neuron #(.THRESHOLD(1048575)) dut_sat (
        .clk(clk), .rst(rst), .step_tick(step_tick), .spk_pre(spk_pre), .weight(weight),
        .time_step(ts1), .spk_post(spk1), .spk_time(st1), .membrane(mem1), .refract(rf1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Drive one cycle, then advance the model by the same cycle and queue its prediction.
    task automatic step(input bit r, input bit t, input bit p, input int unsigned w);
        longint      nv;
        int unsigned old_ts;
        exp_t        e;
        rst = r; step_tick = t; spk_pre = p; weight = w[15:0];
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mv[k] = 0; mts[k] = 0; mleft[k] = 0; mspk[k] = 0; mst[k] = 0;
            end else begin
                old_ts = mts[k];
                mts[k] = (mts[k] + (t ? 1 : 0)) % 256;
                if (mleft[k] > 0) begin
                    mspk[k] = 0; mv[k] = 0;
                    if (t) mleft[k] = mleft[k] - 1;
                end else begin
                    nv = longint'(mv[k]) - (t ? longint'(mv[k] / 16) : 0) + (p ? longint'(w % 65536) : 0);
                    if (nv > 1048575) nv = 1048575;
                    if (nv >= longint'(thr[k])) begin
                        mspk[k] = 1; mst[k] = old_ts; mv[k] = 0; mleft[k] = 3;
                    end else begin
                        mv[k] = int'(nv); mspk[k] = 0;
                    end
                end
            end
            e.mem = 20'(mv[k]);
            e.spk = mspk[k] != 0;
            e.st  = 8'(mst[k]);
            e.rf  = mleft[k] > 0;
            e.ts  = 8'(mts[k]);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("n0_membrane", 32'(mem0), 32'(e.mem));
                chk("n0_spk_post", 32'(spk0), 32'(e.spk));
                chk("n0_spk_time", 32'(st0), 32'(e.st));
                chk("n0_refract", 32'(rf0), 32'(e.rf));
                chk("n0_time_step", 32'(ts0), 32'(e.ts));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sat_membrane", 32'(mem1), 32'(e.mem));
                chk("sat_spk_post", 32'(spk1), 32'(e.spk));
                chk("sat_spk_time", 32'(st1), 32'(e.st));
                chk("sat_refract", 32'(rf1), 32'(e.rf));
                chk("sat_time_step", 32'(ts1), 32'(e.ts));
            end
        end
    end

    initial begin
        repeat (2) step(1, 1, 1, 600);
        step(0, 0, 0, 0);
        step(0, 0, 1, 600);
        step(0, 1, 0, 0);
        step(0, 0, 1, 600);
        for (int i = 0; i < 3; i++) begin
            repeat (3) step(0, 0, 1, 5000);
            step(0, 1, 1, 5000);
        end
        step(0, 0, 1, 5000);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 1, 600);
        step(0, 1, 0, 0);
        step(0, 1, 1, 600);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        repeat (17) step(0, 0, 1, 16'hFFFF);
        repeat (256) step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1200);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1200);
        step(0, 0, 0, 0);
        repeat (3000)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 15) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 1300));
        repeat (2) @(negedge clk);
        chk("n0_queue_drained", 32'(q0.size()), 32'd0);
        chk("sat_queue_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
